ddr_test_gen: RTL and testbench

DDR_TEST_GEN -- requirements
Module: ddr_test_gen

---
 rtl/ddr_test_pkg.sv | 10 +
 rtl/ddr_pattern_gen.sv | 42 ++++
 rtl/ddr_test_gen.sv | 132 +++++++++++++
 tb/tb_ddr_test_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_test_pkg.sv
// ddr_test_pkg: shared states, pattern modes and LFSR constants for the DDR traffic tester
package ddr_test_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WCMD, S_RD, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {MODE_ADDR, MODE_WALK, MODE_LFSR, MODE_INV} mode_t;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/ddr_pattern_gen.sv
// ddr_pattern_gen: produces the data word for (idx, beat) in the selected mode, LFSR stepping per word
module ddr_pattern_gen
  import ddr_test_pkg::*;
#(
  parameter int DW = 128,
  parameter int BEATS = 2,
  parameter int NLOG2 = 10,
  parameter int BW = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             restart,
  input  logic             adv,
  input  mode_t            mode,
  input  logic [NLOG2-1:0] idx,
  input  logic [BW-1:0]    beat,
  output logic [DW-1:0]    word
);
  localparam int PW = NLOG2 + BW;
  logic [31:0] lfsr;
  logic [PW-1:0] pat;
  logic [DW-1:0] rep, lrep, onehot;
  int widx;
  always_ff @(posedge CLK)
    if (Reset) lfsr <= '0;
    else if (restart) lfsr <= LFSR_SEED;
    else if (adv) lfsr <= lfsr_next(lfsr);
  always_comb begin
    pat = {idx, beat};
    rep = '0;
    lrep = '0;
    for (int i = 0; i < DW; i++) begin
      rep[i] = pat[i % PW];
      lrep[i] = lfsr[i % 32];
    end
    widx = (int'(idx) * BEATS + int'(beat)) % DW;
    onehot = {{(DW-1){1'b0}}, 1'b1} << widx;
    word = mode == MODE_ADDR ? rep :
           mode == MODE_WALK ? onehot :
           mode == MODE_LFSR ? lrep : ~rep;
  end
endmodule

// File: rtl/ddr_test_gen.sv
// ddr_test_gen: writes a pattern through the controller, reads it back and counts mismatches
module ddr_test_gen
  import ddr_test_pkg::*;
#(
  parameter int DW = 128,
  parameter int AW = 28,
  parameter int BEATS = 2,
  parameter int NLOG2 = 10,
  parameter int MAXOUT = 8,
  parameter int ECW = 16
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           Start,
  input  logic [1:0]     Mode,
  input  logic           Loop,
  input  logic           Stop,
  output logic [AW-1:0]  Address,
  output logic           Read,
  output logic           WriteAF,
  input  logic           AFfull,
  output logic [DW-1:0]  WriteData,
  output logic           WriteWB,
  input  logic           WBfull,
  input  logic [DW-1:0]  ReadData,
  input  logic           RBempty,
  output logic           ReadRB,
  input  logic           SingleError,
  input  logic           DoubleError,
  output logic           Busy,
  output logic           Done,
  output logic           Fail,
  output logic [ECW-1:0] ErrCount,
  output logic [AW-1:0]  FirstErrAddr,
  output logic [1:0]     ErrLeds
);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int OW = $clog2(MAXOUT + 1);
  localparam logic [NLOG2-1:0] LAST_IDX = '1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  state_t state;
  mode_t mode_q;
  logic [NLOG2-1:0] idx, chk_idx;
  logic [BW-1:0] wbeat, cbeat;
  logic [OW-1:0] outst;
  logic stop_seen, go, pop, rd_push, cmd_done, mism, pass_again, restart;
  logic [DW-1:0] chk_word;
  always_comb begin
    go = Start && (state == S_IDLE || state == S_DONE);
    Busy = state != S_IDLE && state != S_DONE;
    Done = state == S_DONE;
    WriteWB = state == S_WDATA && !WBfull;
    Read = state == S_RD;
    WriteAF = !AFfull && (state == S_WCMD || (state == S_RD && outst < OW'(MAXOUT)));
    rd_push = WriteAF && Read;
    Address = AW'(idx);
    ReadRB = (state == S_RD || state == S_DRAIN) && !RBempty;
    pop = ReadRB && outst != '0;
    cmd_done = pop && cbeat == LAST_BEAT;
    mism = pop && ReadData != chk_word;
    pass_again = state == S_DRAIN && outst == '0 && Loop && !stop_seen;
    restart = go || pass_again;
  end
  ddr_pattern_gen #(.DW(DW), .BEATS(BEATS), .NLOG2(NLOG2), .BW(BW)) u_wr_gen (
    .CLK(CLK), .Reset(Reset), .restart(restart), .adv(WriteWB), .mode(mode_q),
    .idx(idx), .beat(wbeat), .word(WriteData)
  );
  ddr_pattern_gen #(.DW(DW), .BEATS(BEATS), .NLOG2(NLOG2), .BW(BW)) u_chk_gen (
    .CLK(CLK), .Reset(Reset), .restart(restart), .adv(pop), .mode(mode_q),
    .idx(chk_idx), .beat(cbeat), .word(chk_word)
  );
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
      mode_q <= MODE_ADDR;
      idx <= '0;
      chk_idx <= '0;
      wbeat <= '0;
      cbeat <= '0;
      outst <= '0;
      stop_seen <= 1'b0;
      ErrCount <= '0;
      Fail <= 1'b0;
      FirstErrAddr <= '0;
      ErrLeds <= '0;
    end else begin
      ErrLeds <= (go ? 2'b00 : ErrLeds) | {DoubleError, SingleError};
      stop_seen <= go ? 1'b0 : stop_seen | (Busy && Stop);
      if (go) begin
        state <= S_WDATA;
        mode_q <= mode_t'(Mode);
        idx <= '0;
        chk_idx <= '0;
        wbeat <= '0;
        cbeat <= '0;
        outst <= '0;
        ErrCount <= '0;
        Fail <= 1'b0;
        FirstErrAddr <= '0;
      end else begin
        case (state)
          S_WDATA: if (WriteWB) begin
            wbeat <= wbeat == LAST_BEAT ? '0 : wbeat + BW'(1);
            if (wbeat == LAST_BEAT) state <= S_WCMD;
          end
          S_WCMD: if (WriteAF) begin
            idx <= idx + NLOG2'(1);
            state <= idx == LAST_IDX ? S_RD : S_WDATA;
          end
          S_RD: if (WriteAF) begin
            idx <= idx + NLOG2'(1);
            if (idx == LAST_IDX) state <= S_DRAIN;
          end
          S_DRAIN: if (outst == '0) state <= pass_again ? S_WDATA : S_DONE;
          default: ;
        endcase
        outst <= outst + OW'(rd_push) - OW'(cmd_done);
        if (pop) cbeat <= cbeat == LAST_BEAT ? '0 : cbeat + BW'(1);
        if (cmd_done) chk_idx <= chk_idx + NLOG2'(1);
        if (pass_again) begin
          chk_idx <= '0;
          cbeat <= '0;
        end
        if (mism) begin
          if (ErrCount != '1) ErrCount <= ErrCount + ECW'(1);
          Fail <= 1'b1;
          if (ErrCount == '0) FirstErrAddr <= AW'(chk_idx);
        end
      end
    end
  end
endmodule

// File: tb/tb_ddr_test_gen.sv
// tb_ddr_test_gen: directed checks of ddr_test_gen against an ideal controller model
module tb_ddr_test_gen;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BEATS = 2;
  localparam int NLOG2 = 2;
  localparam int MAXOUT = 2;
  localparam int ECW = 6;
  logic CLK = 1'b0;
  logic Reset = 1'b1, Start = 1'b0, Loop = 1'b0, Stop = 1'b0;
  logic [1:0] Mode = 2'd0;
  logic AFfull = 1'b0, WBfull = 1'b0, SingleError = 1'b0, DoubleError = 1'b0;
  logic RBempty = 1'b1;
  logic [DW-1:0] ReadData = '0;
  logic [AW-1:0] Address, FirstErrAddr;
  logic Read, WriteAF, WriteWB, ReadRB, Busy, Done, Fail;
  logic [DW-1:0] WriteData;
  logic [ECW-1:0] ErrCount;
  logic [1:0] ErrLeds;
  int errs = 0, checks = 0;
  int n_wb, n_wcmd, n_rcmd, bo, bo_max, af_viol, rpop;
  bit corrupt, invert_all;
  logic [1:0] cur_mode;
  logic [31:0] bl;
  logic [DW-1:0] wq[$], rq[$];
  logic [DW-1:0] mem [4][2];
  always #5 CLK = ~CLK;
  ddr_test_gen #(.DW(DW), .AW(AW), .BEATS(BEATS), .NLOG2(NLOG2), .MAXOUT(MAXOUT), .ECW(ECW)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Mode(Mode), .Loop(Loop), .Stop(Stop),
    .Address(Address), .Read(Read), .WriteAF(WriteAF), .AFfull(AFfull),
    .WriteData(WriteData), .WriteWB(WriteWB), .WBfull(WBfull),
    .ReadData(ReadData), .RBempty(RBempty), .ReadRB(ReadRB),
    .SingleError(SingleError), .DoubleError(DoubleError),
    .Busy(Busy), .Done(Done), .Fail(Fail), .ErrCount(ErrCount),
    .FirstErrAddr(FirstErrAddr), .ErrLeds(ErrLeds)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction
  function automatic logic [63:0] exp_word(input logic [1:0] m, input logic [1:0] a, input logic b, input logic [31:0] l);
    logic [2:0] p;
    logic [63:0] r;
    p = {a, b};
    for (int i = 0; i < 64; i++) r[i] = p[i % 3];
    case (m)
      2'd0: return r;
      2'd1: return 64'd1 << (int'(a) * 2 + int'(b));
      2'd2: return {l, l};
      default: return ~r;
    endcase
  endfunction
  always @(posedge CLK) begin
    if (Reset) begin
      wq.delete();
      rq.delete();
      bo = 0;
      rpop = 0;
      RBempty <= 1'b1;
      ReadData <= '0;
    end else begin
      if (ReadRB && rq.size() > 0) begin
        void'(rq.pop_front());
        rpop++;
        if (rpop == BEATS) begin
          rpop = 0;
          bo--;
        end
      end
      if (WriteWB) begin
        wq.push_back(WriteData);
        n_wb++;
      end
      if (WriteAF && AFfull) af_viol++;
      if (WriteAF && !Read) begin
        n_wcmd++;
        for (int b = 0; b < BEATS; b++) begin
          mem[Address[1:0]][b] = wq.size() > 0 ? wq.pop_front() : '0;
          if (Address[1:0] == 2'd0 && b == 0) bl = 32'h1;
          chk("wdata", mem[Address[1:0]][b], exp_word(cur_mode, Address[1:0], b[0], bl));
          bl = step(bl);
        end
      end
      if (WriteAF && Read) begin
        n_rcmd++;
        bo++;
        if (bo > bo_max) bo_max = bo;
        for (int b = 0; b < BEATS; b++) begin
          logic [DW-1:0] d;
          d = mem[Address[1:0]][b];
          if (corrupt && Address[1:0] == 2'd3 && b == 1) d[5] = ~d[5];
          if (invert_all) d = ~d;
          rq.push_back(d);
        end
      end
      RBempty <= rq.size() == 0;
      ReadData <= rq.size() > 0 ? rq[0] : '0;
    end
  end
  task automatic start(input logic [1:0] m, input logic l);
    n_wb = 0;
    n_wcmd = 0;
    n_rcmd = 0;
    bo_max = 0;
    af_viol = 0;
    cur_mode = m;
    Mode = m;
    Loop = l;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    int n = 0;
    while (!Done && n < lim) begin
      @(negedge CLK);
      n++;
    end
    chk("done_reached", Done, 1);
  endtask
  task automatic check_clean(input string tag, input int passes);
    chk({tag, "_wb"}, n_wb, 8 * passes);
    chk({tag, "_wcmd"}, n_wcmd, 4 * passes);
    chk({tag, "_rcmd"}, n_rcmd, 4 * passes);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_errcount"}, ErrCount, 0);
    chk({tag, "_fail"}, Fail, 0);
  endtask
  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_outputs", {WriteAF, WriteWB, Read, ReadRB, Fail, ErrLeds}, 0);
    chk("rst_errcount", ErrCount, 0);
    Reset = 1'b0;
    @(negedge CLK);
    start(2'd0, 1'b0);
    chk("m0_busy", Busy, 1);
    wait_done(500);
    check_clean("m0", 1);
    @(negedge CLK);
    start(2'd1, 1'b0);
    WBfull = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("wbfull_hold", WriteWB, 0);
    end
    WBfull = 1'b0;
    wait_done(500);
    check_clean("m1", 1);
    start(2'd3, 1'b0);
    wait_done(500);
    check_clean("m3", 1);
    corrupt = 1'b1;
    start(2'd2, 1'b0);
    wait_done(500);
    corrupt = 1'b0;
    chk("m2_errcount", ErrCount, 1);
    chk("m2_firsterr", FirstErrAddr, 3);
    chk("m2_fail", Fail, 1);
    SingleError = 1'b1;
    @(negedge CLK);
    SingleError = 1'b0;
    @(negedge CLK);
    chk("leds_single", ErrLeds, 2'b01);
    DoubleError = 1'b1;
    @(negedge CLK);
    DoubleError = 1'b0;
    @(negedge CLK);
    chk("leds_both", ErrLeds, 2'b11);
    start(2'd0, 1'b0);
    chk("leds_cleared", ErrLeds, 2'b00);
    chk("restart_fail_clr", Fail, 0);
    for (int n = 0; n < 200 && !Read; n++) @(negedge CLK);
    chk("rd_reached", Read, 1);
    AFfull = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      chk("affull_hold", WriteAF, 0);
    end
    AFfull = 1'b0;
    wait_done(500);
    check_clean("affull", 1);
    chk("af_viol", af_viol, 0);
    chk("outstanding_le_max", bo_max <= MAXOUT, 1);
    start(2'd2, 1'b1);
    for (int n = 0; n < 500 && n_wcmd < 5; n++) @(negedge CLK);
    chk("pass2_reached", n_wcmd >= 5, 1);
    Stop = 1'b1;
    @(negedge CLK);
    Stop = 1'b0;
    wait_done(1000);
    check_clean("loop", 2);
    start(2'd0, 1'b0);
    chk("wdata_busy", {Busy, WriteWB}, 2'b11);
    Reset = 1'b1;
    @(negedge CLK);
    chk("midrst_busy", Busy, 0);
    chk("midrst_strobes", {Done, Fail, WriteAF, WriteWB, Read, ReadRB, ErrLeds}, 0);
    chk("midrst_addr", {Address, FirstErrAddr, ErrCount}, 0);
    chk("midrst_wdata", WriteData, 0);
    Reset = 1'b0;
    @(negedge CLK);
    start(2'd2, 1'b0);
    wait_done(500);
    check_clean("after_rst", 1);
    invert_all = 1'b1;
    start(2'd0, 1'b1);
    for (int n = 0; n < 3000 && n_rcmd < 32; n++) @(negedge CLK);
    chk("sat_passes", n_rcmd >= 32, 1);
    Stop = 1'b1;
    @(negedge CLK);
    Stop = 1'b0;
    wait_done(1000);
    invert_all = 1'b0;
    chk("sat_errcount", ErrCount, 6'h3F);
    chk("sat_fail", Fail, 1);
    chk("sat_firsterr", FirstErrAddr, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
